// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the multi-channel PWM generator.
//   PWM_EDGE / PWM_CENTER : alignment mode encodings for the mode register
//   dir_t                 : count direction used by the center-aligned counter
//   sel_width()           : width of a channel-select field for N channels
// ---------------------------------------------------------------------------
package pwm_pkg;

    localparam logic PWM_EDGE   = 1'b0;
    localparam logic PWM_CENTER = 1'b1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // A single channel still needs a one-bit select port, so never return 0.
    function automatic int sel_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/pwm_chan.sv
// ---------------------------------------------------------------------------
// pwm_chan
// One PWM output channel: shadow duty register, active duty register and the
// registered comparator against the shared period counter.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   en         : run enable; output is forced low while deasserted
//   load       : copy shadow duty into the active duty this edge
//   duty_wr    : write strobe for the shadow duty
//   duty_sel   : channel index of the write; only IDX is accepted here
//   duty_data  : value written into the shadow duty
//   cnt        : shared period counter
//   pwm        : registered PWM output
// ---------------------------------------------------------------------------
module pwm_chan #(
    parameter int BITS  = 8,
    parameter int SEL_W = 2,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             duty_wr,
    input  logic [SEL_W-1:0] duty_sel,
    input  logic [BITS-1:0]  duty_data,
    input  logic [BITS-1:0]  cnt,
    output logic             pwm
);

    localparam logic [SEL_W-1:0] MY_SEL = SEL_W'(IDX);

    logic [BITS-1:0] duty_shadow;
    logic [BITS-1:0] duty_act;
    logic            sel_hit;

    // Out-of-range select values simply match no channel, so such writes
    // are dropped without any extra range check.
    assign sel_hit = duty_wr && (duty_sel == MY_SEL);

    // The active duty takes the shadow value from before this edge, so a
    // write landing on the same edge as a load is deferred by one period.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_shadow <= '0;
            duty_act    <= '0;
            pwm         <= 1'b0;
        end else begin
            if (sel_hit) begin
                duty_shadow <= duty_data;
            end
            if (load) begin
                duty_act <= duty_shadow;
            end
            pwm <= en && (cnt < duty_act);
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// ---------------------------------------------------------------------------
// pwm_multi
// Multi-channel PWM generator with one shared prescaler and period counter,
// programmable period, edge- or center-aligned counting and double-buffered
// duty/period/mode registers that only take effect at period boundaries.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   en         : run enable; counters hold and outputs go low when 0
//   center     : alignment mode request (0 edge, 1 center), boundary-sampled
//   prescale   : counter advances once every prescale+1 clocks
//   period     : requested top count, boundary-sampled
//   duty_wr    : one-cycle write strobe for a channel shadow duty
//   duty_sel   : channel index for the write
//   duty_data  : duty value (number of counts the output is high)
//   pwm        : registered PWM outputs, one per channel
//   period_end : one-cycle pulse following every period boundary
// ---------------------------------------------------------------------------
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int BITS       = 8,
    parameter int CHANNELS   = 4,
    parameter int PRESC_BITS = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            center,
    input  logic [PRESC_BITS-1:0]           prescale,
    input  logic [BITS-1:0]                 period,
    input  logic                            duty_wr,
    input  logic [sel_width(CHANNELS)-1:0]  duty_sel,
    input  logic [BITS-1:0]                 duty_data,
    output logic [CHANNELS-1:0]             pwm,
    output logic                            period_end
);

    localparam int SEL_W = sel_width(CHANNELS);

    logic [PRESC_BITS-1:0] presc_cnt;
    logic [PRESC_BITS-1:0] presc_nxt;
    logic [BITS-1:0]       cnt;
    logic [BITS-1:0]       cnt_nxt;
    logic [BITS-1:0]       period_act;
    logic                  mode;
    dir_t                  dir;
    dir_t                  dir_nxt;
    logic                  tick;
    logic                  boundary;
    logic                  load;

    // The >= compare keeps the prescaler from running the long way round
    // if prescale is lowered below the current count.
    assign tick = en && (presc_cnt >= prescale);

    // While disabled the active registers track their shadows every cycle,
    // so new settings are in force the moment counting resumes.
    assign load = boundary || !en;

    // Next-state logic for prescaler, period counter and count direction.
    // The >= compares matter after a disabled interval reloaded a smaller
    // period under a held count: the counter then wraps or turns at once
    // instead of sweeping the whole counter range.
    always_comb begin
        presc_nxt = presc_cnt;
        cnt_nxt   = cnt;
        dir_nxt   = dir;
        boundary  = 1'b0;

        if (en) begin
            presc_nxt = tick ? '0 : presc_cnt + PRESC_BITS'(1);
        end

        if (tick) begin
            if (mode == PWM_EDGE) begin
                if (cnt >= period_act) begin
                    boundary = 1'b1;
                end else begin
                    cnt_nxt = cnt + BITS'(1);
                end
            end else begin
                if (period_act == '0) begin
                    boundary = 1'b1;
                end else if (dir == DIR_UP) begin
                    if (cnt >= period_act) begin
                        // With a top of 1 the turn-around step lands on 0,
                        // which is itself the end of the period.
                        if (period_act == BITS'(1)) begin
                            boundary = 1'b1;
                        end else begin
                            cnt_nxt = period_act - BITS'(1);
                            dir_nxt = DIR_DOWN;
                        end
                    end else begin
                        cnt_nxt = cnt + BITS'(1);
                    end
                end else begin
                    if (cnt <= BITS'(1)) begin
                        boundary = 1'b1;
                    end else begin
                        cnt_nxt = cnt - BITS'(1);
                    end
                end
            end

            if (boundary) begin
                cnt_nxt = '0;
                dir_nxt = DIR_UP;
            end
        end
    end

    // Counter state plus the boundary-sampled period and mode registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt  <= '0;
            cnt        <= '0;
            dir        <= DIR_UP;
            period_act <= '0;
            mode       <= PWM_EDGE;
            period_end <= 1'b0;
        end else begin
            presc_cnt  <= presc_nxt;
            cnt        <= cnt_nxt;
            dir        <= dir_nxt;
            period_end <= boundary;
            if (load) begin
                period_act <= period;
                mode       <= center;
            end
        end
    end

    // One comparator channel per output, all sharing the counter and load.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        pwm_chan #(
            .BITS  (BITS),
            .SEL_W (SEL_W),
            .IDX   (i)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .load      (load),
            .duty_wr   (duty_wr),
            .duty_sel  (duty_sel),
            .duty_data (duty_data),
            .cnt       (cnt),
            .pwm       (pwm[i])
        );
    end

endmodule
